hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register index width AW = clog2(NREG).
REQ-002 Parameter ALU_LAT, default 1: result latency of ALU-class producers, in cycles.
REQ-003 Parameter LOAD_LAT, default 2: result latency of load-class producers.
REQ-004 Parameter MDU_LAT, default 8: result latency and busy time of the non-pipelined multiply/divide unit.
REQ-005 Parameter CW, default 4: scoreboard counter width; every *_LAT SHALL be in 1..2^CW-1.
REQ-006 Clock: clk, input, 1 bit, all state on rising edge.
REQ-007 Reset: rst, input, 1 bit, asynchronous, active-high.
REQ-008 id_valid, input, 1: ID holds a valid instruction.
REQ-009 id_rs1 / id_rs2, input, AW each: source register indices.
REQ-010 id_rs1_used / id_rs2_used, input, 1 each: source is actually read (rs2_used low for immediate forms).
REQ-011 id_rd, input, AW; id_rd_we, input, 1: destination and write enable.
REQ-012 id_class, input, 2: producer class, ALU / LOAD / MDU.
REQ-013 id_early, input, 1: branch or jump; operands are consumed in ID.
REQ-014 flush, input, 1: squash the ID instruction this cycle.
REQ-015 stall, output, 1: hold IF/ID, insert a bubble into EX.
REQ-016 issue, output, 1: ID instruction leaves ID this cycle.
REQ-017 stall_cause, output, 2: NONE / RAW / WAW / STRUCT.
REQ-018 mdu_busy, output, 1: MDU counter non-zero.

Function
REQ-019 Each register r SHALL have a counter cnt[r] (CW bits) giving the cycles until its pending result is forwardable; index 0 SHALL never be set and SHALL always read 0.
REQ-020 issue = id_valid & !flush & !stall; stall SHALL be 0 whenever flush=1 or id_valid=0.
REQ-021 RAW: for each used source s != 0, stall when id_early=0 and cnt[s] > 1, or when id_early=1 and cnt[s] != 0.
REQ-022 WAW: stall when id_rd_we, id_rd != 0 and cnt[id_rd] > lat(id_class).
REQ-023 STRUCT: stall when id_class=MDU and mdu_cnt != 0.
REQ-024 stall_cause priority SHALL be RAW > WAW > STRUCT; NONE when stall=0.
REQ-025 Each cycle every non-zero counter SHALL decrement by 1.
REQ-026 On issue with id_rd_we and id_rd != 0, cnt[id_rd] SHALL load lat(id_class) on the same edge; the load SHALL override that register's decrement.
REQ-027 On issue with id_class=MDU, mdu_cnt SHALL load MDU_LAT; otherwise it decrements to 0.
REQ-028 stall, issue and stall_cause SHALL be combinational from current state and inputs, with zero-cycle latency; counters update one edge later.
REQ-029 Expected bubble counts: ALU->use 0, load->use 1, ALU->branch 1, load->branch 2.

Reset
REQ-030 rst SHALL clear all cnt[], mdu_cnt and perf state to 0 immediately, including mid-stall; outputs then reflect an empty scoreboard (stall=0, mdu_busy=0).

Configuration
REQ-031 With HAZARD_PERF_EN defined, the block SHALL add outputs perf_stall_cycles (32 bits, increments each stall cycle) and perf_raw_cycles (32 bits, increments each RAW stall); both saturate at all-ones and reset to 0.
REQ-032 Without HAZARD_PERF_EN, these ports and their counters SHALL NOT exist.

Structure
REQ-033 Package hazard_pkg SHALL hold the id_class encodings (ALU=0, LOAD=1, MDU=2) and the stall_cause encodings (NONE=0, RAW=1, WAW=2, STRUCT=3).
REQ-034 Sub-module hazard_sb_cell SHALL implement one counter with load/decrement, instantiated NREG-1 times, plus once for the MDU.

Verification
REQ-035 LOAD to x5, then ADD reading x5 -> stall=1 with cause RAW for 1 cycle, then issue.
REQ-036 ALU write to x7, then branch reading x7 (id_early=1) -> 1 stall cycle; the same case after a LOAD -> 2 stall cycles.
REQ-037 MDU to x3 (MDU_LAT=8), then ALU writing x3 -> WAW stall until cnt[3] <= 1; a second MDU op -> STRUCT stall for 8 cycles after the first issue.
REQ-038 Writes to x0 and reads of x0 -> never stall; cnt[0] stays 0.
REQ-039 rst asserted during a load-use stall -> stall=0 asynchronously; the next ID instruction issues.
REQ-040 flush=1 with a hazard present -> stall=0, issue=0, no counter loaded; with HAZARD_PERF_EN defined, perf_stall_cycles is unchanged.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: producer classes, stall causes
// and the class-to-latency mapping.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MDU  = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_RAW    = 2'd1,
    CAUSE_WAW    = 2'd2,
    CAUSE_STRUCT = 2'd3
  } cause_e;

  // The unused class encoding falls back to ALU timing.
  function automatic int unsigned classLat(input cls_e c, input int unsigned aluLat,
                                           input int unsigned loadLat, input int unsigned mduLat);
    case (c)
      CLS_LOAD: return loadLat;
      CLS_MDU:  return mduLat;
      default:  return aluLat;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to scoreboard bundle: the decoded instruction and flush go in,
// the stall/issue decision comes back.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int NREG = 32
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_rd_we;
  cls_e          id_class;
  logic          id_early;
  logic          flush;
  logic          stall;
  logic          issue;
  cause_e        stall_cause;
  logic          mdu_busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_class, id_early, flush,
    input  stall, issue, stall_cause, mdu_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_class, id_early, flush,
    output stall, issue, stall_cause, mdu_busy
  );

endinterface

// File: rtl/hazard_scoreboard_sb_cell.sv
// One scoreboard counter: loads a latency on request, otherwise counts down
// to zero and holds there.
module hazard_sb_cell #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_loadVal,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // A load wins over the decrement so a re-issued destination restarts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_loadVal;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard deciding ID stalls (RAW / WAW / MDU structural).
// Define HAZARD_PERF_EN to add saturating stall/RAW-stall cycle counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MDU_LAT  = 8,
  parameter int CW       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   sb
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_raw_cycles
`endif
);

  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int NSLOT = 1 << AW;

  logic [CW-1:0] w_cnt [NSLOT];
  logic [CW-1:0] w_mduCnt;
  logic [CW-1:0] w_lat;
  logic          w_rs1Haz;
  logic          w_rs2Haz;
  logic          w_raw;
  logic          w_waw;
  logic          w_struct;
  logic          w_stall;
  logic          w_issue;
  cause_e        w_cause;

  assign w_lat = CW'(classLat(sb.id_class, ALU_LAT, LOAD_LAT, MDU_LAT));

  // Slot 0 and any index beyond NREG are hard-wired empty.
  for (genvar g = 0; g < NSLOT; g++) begin : gCell
    if (g == 0 || g >= NREG) begin : gZero
      assign w_cnt[g] = '0;
    end else begin : gReg
      hazard_sb_cell #(.CW(CW)) uCell (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_issue && sb.id_rd_we && (sb.id_rd == AW'(g))),
        .i_loadVal (w_lat),
        .o_cnt     (w_cnt[g])
      );
    end
  end

  hazard_sb_cell #(.CW(CW)) uMduCell (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_issue && (sb.id_class == CLS_MDU)),
    .i_loadVal (CW'(MDU_LAT)),
    .o_cnt     (w_mduCnt)
  );

  // Branches consume operands in ID, so they cannot use the EX forward of a count of 1.
  assign w_rs1Haz = sb.id_rs1_used && (sb.id_rs1 != '0) &&
                    (sb.id_early ? (w_cnt[sb.id_rs1] != '0) : (w_cnt[sb.id_rs1] > CW'(1)));
  assign w_rs2Haz = sb.id_rs2_used && (sb.id_rs2 != '0) &&
                    (sb.id_early ? (w_cnt[sb.id_rs2] != '0) : (w_cnt[sb.id_rs2] > CW'(1)));
  assign w_raw    = w_rs1Haz || w_rs2Haz;
  assign w_waw    = sb.id_rd_we && (sb.id_rd != '0) && (w_cnt[sb.id_rd] > w_lat);
  assign w_struct = (sb.id_class == CLS_MDU) && (w_mduCnt != '0);

  assign w_stall  = sb.id_valid && !sb.flush && (w_raw || w_waw || w_struct);
  assign w_issue  = sb.id_valid && !sb.flush && !w_stall;

  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_stall) begin
      if (w_raw)      w_cause = CAUSE_RAW;
      else if (w_waw) w_cause = CAUSE_WAW;
      else            w_cause = CAUSE_STRUCT;
    end
  end

  assign sb.stall       = w_stall;
  assign sb.issue       = w_issue;
  assign sb.stall_cause = w_cause;
  assign sb.mdu_busy    = (w_mduCnt != '0);

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perfStall;
  logic [31:0] r_perfRaw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfStall <= '0;
      r_perfRaw   <= '0;
    end else begin
      if (w_stall && (r_perfStall != '1)) r_perfStall <= r_perfStall + 32'd1;
      if (w_stall && w_raw && (r_perfRaw != '1)) r_perfRaw <= r_perfRaw + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perfStall;
  assign perf_raw_cycles   = r_perfRaw;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// checked every cycle against a readiness-time model of the register file.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREG     = 32;
  localparam int AW       = $clog2(NREG);
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int MDU_LAT  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG)) sbIf ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perfStall;
  logic [31:0] perfRaw;
`endif

  hazard_scoreboard #(
    .NREG(NREG), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT), .CW(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbIf.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perfStall),
    .perf_raw_cycles   (perfRaw)
`endif
  );

  int      vectors     = 0;
  int      miscompares = 0;
  longint  now         = 0;
  longint  readyAt [NREG];
  longint  mduFreeAt;
  longint  expPerfStall;
  longint  expPerfRaw;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  // Model: each register is ready for forwarding at an absolute cycle number.
  function automatic int remaining(input int r);
    if (r == 0) return 0;
    return (readyAt[r] > now) ? int'(readyAt[r] - now) : 0;
  endfunction

  function automatic int latOf(input int cls);
    if (cls == 1) return LOAD_LAT;
    if (cls == 2) return MDU_LAT;
    return ALU_LAT;
  endfunction

  task automatic resetModel();
    foreach (readyAt[i]) readyAt[i] = 0;
    mduFreeAt    = 0;
    expPerfStall = 0;
    expPerfRaw   = 0;
  endtask

  task automatic applyStimulus(input bit valid, input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit we, input int cls, input bit early, input bit fl,
                               output bit issued, output int cause);
    bit raw, waw, str, expStall, expIssue;
    int expCause;
    @(negedge clk);
    sbIf.id_valid    = valid;
    sbIf.id_rs1      = rs1[AW-1:0];
    sbIf.id_rs1_used = u1;
    sbIf.id_rs2      = rs2[AW-1:0];
    sbIf.id_rs2_used = u2;
    sbIf.id_rd       = rd[AW-1:0];
    sbIf.id_rd_we    = we;
    sbIf.id_class    = cls_e'(cls[1:0]);
    sbIf.id_early    = early;
    sbIf.flush       = fl;
    #1;
    raw = (u1 && rs1 != 0 && (early ? remaining(rs1) > 0 : remaining(rs1) > 1)) ||
          (u2 && rs2 != 0 && (early ? remaining(rs2) > 0 : remaining(rs2) > 1));
    waw = we && rd != 0 && remaining(rd) > latOf(cls);
    str = (cls == 2) && (mduFreeAt > now);
    expStall = valid && !fl && (raw || waw || str);
    expIssue = valid && !fl && !expStall;
    expCause = !expStall ? 0 : raw ? 1 : waw ? 2 : 3;
    checkOutput("stall", sbIf.stall, expStall);
    checkOutput("issue", sbIf.issue, expIssue);
    checkOutput("cause", sbIf.stall_cause, expCause);
    checkOutput("mduBusy", sbIf.mdu_busy, mduFreeAt > now);
`ifdef HAZARD_PERF_EN
    checkOutput("perfStall", perfStall, expPerfStall);
    checkOutput("perfRaw", perfRaw, expPerfRaw);
`endif
    issued = sbIf.issue;
    cause  = int'(sbIf.stall_cause);
    if (expStall) expPerfStall++;
    if (expStall && raw) expPerfRaw++;
    if (expIssue) begin
      if (we && rd != 0) readyAt[rd] = now + 1 + latOf(cls);
      if (cls == 2) mduFreeAt = now + 1 + MDU_LAT;
    end
    now++;
  endtask

  task automatic idle(input int n);
    bit iss;
    int c;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iss, c);
  endtask

  task automatic waitIssue(input int rs1, input bit u1, input int rs2, input bit u2, input int rd,
                           input bit we, input int cls, input bit early,
                           output int stalls, output int firstCause);
    bit iss;
    int c;
    stalls     = 0;
    firstCause = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, rs1, u1, rs2, u2, rd, we, cls, early, 0, iss, c);
      if (iss) return;
      if (stalls == 0) firstCause = c;
      stalls++;
    end
    checkOutput("issueTimeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  st, fc;
    bit  iss;
    int  c;

    rst = 1'b1;
    sbIf.id_valid = 0; sbIf.id_rs1 = '0; sbIf.id_rs2 = '0; sbIf.id_rs1_used = 0;
    sbIf.id_rs2_used = 0; sbIf.id_rd = '0; sbIf.id_rd_we = 0; sbIf.id_class = CLS_ALU;
    sbIf.id_early = 0; sbIf.flush = 0;
    resetModel();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetStall", sbIf.stall, 0);
    checkOutput("resetMduBusy", sbIf.mdu_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Load-use: one RAW bubble.
    waitIssue(0, 0, 0, 0, 5, 1, 1, 0, st, fc);
    waitIssue(5, 1, 6, 1, 8, 1, 0, 0, st, fc);
    checkOutput("loadUseBubbles", st, 1);
    checkOutput("loadUseCause", fc, 1);

    idle(4);
    waitIssue(0, 0, 0, 0, 9, 1, 0, 0, st, fc);
    waitIssue(9, 1, 0, 0, 10, 1, 0, 0, st, fc);
    checkOutput("aluUseBubbles", st, 0);

    idle(4);
    waitIssue(0, 0, 0, 0, 7, 1, 0, 0, st, fc);
    waitIssue(7, 1, 0, 0, 0, 0, 0, 1, st, fc);
    checkOutput("aluBranchBubbles", st, 1);

    idle(4);
    waitIssue(0, 0, 0, 0, 7, 1, 1, 0, st, fc);
    waitIssue(7, 1, 0, 0, 0, 0, 0, 1, st, fc);
    checkOutput("loadBranchBubbles", st, 2);

    // Back-to-back MDU ops hit the structural hazard, then an ALU write hits WAW.
    idle(10);
    waitIssue(0, 0, 0, 0, 3, 1, 2, 0, st, fc);
    waitIssue(0, 0, 0, 0, 4, 1, 2, 0, st, fc);
    checkOutput("mduStructBubbles", st, 8);
    checkOutput("mduStructCause", fc, 3);
    waitIssue(0, 0, 0, 0, 4, 1, 0, 0, st, fc);
    checkOutput("mduWawBubbles", st, 7);
    checkOutput("mduWawCause", fc, 2);

    idle(10);
    waitIssue(0, 0, 0, 0, 0, 1, 1, 0, st, fc);
    waitIssue(0, 1, 0, 1, 0, 1, 0, 1, st, fc);
    checkOutput("x0Bubbles", st, 0);

    // A flushed instruction must not mark its destination busy.
    idle(4);
    waitIssue(0, 0, 0, 0, 5, 1, 1, 0, st, fc);
    applyStimulus(1, 5, 1, 0, 0, 6, 1, 2, 0, 1, iss, c);
    waitIssue(6, 1, 0, 0, 0, 0, 0, 1, st, fc);
    checkOutput("flushNoLoad", st, 0);

    // Reset asserted in the middle of a load-use stall.
    idle(4);
    waitIssue(0, 0, 0, 0, 5, 1, 1, 0, st, fc);
    @(negedge clk);
    sbIf.id_valid = 1; sbIf.id_rs1 = 5'd5; sbIf.id_rs1_used = 1; sbIf.id_rs2_used = 0;
    sbIf.id_rd = 5'd8; sbIf.id_rd_we = 1; sbIf.id_class = CLS_ALU; sbIf.id_early = 0; sbIf.flush = 0;
    #1;
    checkOutput("preResetStall", sbIf.stall, 1);
    rst = 1'b1;
    #1;
    checkOutput("midResetStall", sbIf.stall, 0);
    checkOutput("midResetMduBusy", sbIf.mdu_busy, 0);
`ifdef HAZARD_PERF_EN
    checkOutput("midResetPerf", perfStall, 0);
`endif
    sbIf.id_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    now++;
    waitIssue(5, 1, 0, 0, 8, 1, 0, 0, st, fc);
    checkOutput("postResetIssue", st, 0);

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) == 0, iss, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
